// File: rtl/config_memory_unit.sv
// config_memory_unit: config slot memory with rotating syskey and registered readback
module config_memory_unit #(
    parameter int               DEPTH    = 4,
    parameter int               CFG_W    = 35,
    parameter int               KEY_W    = 2,
    parameter logic [KEY_W-1:0] KEY_SEED = 2'b10,
    parameter int               AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             write_en,
    input  logic [CFG_W-1:0] configin,
    input  logic             clr,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [KEY_W-1:0] syskey,
    output logic [CFG_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             full,
    output logic [AW:0]      count,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'b00, COMMIT = 2'b01, HOLD = 2'b10, ILL = 2'b11} state_t;
    state_t state, state_nx;
    logic [CFG_W-1:0] staged;
    logic [CFG_W-1:0] slot [DEPTH];
    logic commit_ok, commit_rej, rd_hit;
    assign full       = count == (AW+1)'(DEPTH);
    assign commit_ok  = state == COMMIT && !clr && !full;
    assign commit_rej = state == COMMIT && !clr && full;
    assign rd_hit     = {1'b0, rd_addr} < count;
    assign dbg_state  = state;
    // state register; the illegal encoding falls back to IDLE through state_nx
    always_ff @(posedge clk) begin
        if (arst) state <= IDLE;
        else      state <= state_nx;
    end
    // next state: one commit per write_en assertion, HOLD absorbs a held request
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = write_en ? COMMIT : IDLE;
            COMMIT:  state_nx = HOLD;
            HOLD:    state_nx = write_en ? HOLD : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // counters, key rotation, response pulses and readback register
    always_ff @(posedge clk) begin
        if (arst) begin
            count    <= '0;
            syskey   <= KEY_SEED;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
            staged   <= '0;
        end else begin
            if (state == IDLE && write_en) staged <= configin;
            count    <= clr ? '0 : commit_ok ? count + 1'b1 : count;
            syskey   <= commit_ok ? syskey + 1'b1 : syskey;
            wr_ack   <= commit_ok;
            wr_err   <= commit_rej;
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_hit;
            if (rd_en) rd_data <= rd_hit ? slot[rd_addr] : '0;
        end
    end
    // slot storage is not reset; a write is dropped when reset lands on the commit edge
    always_ff @(posedge clk) begin
        if (!arst && commit_ok) slot[count[AW-1:0]] <= staged;
    end
endmodule

// File: tb/tb_config_memory_unit.sv
// tb_config_memory_unit: directed checks of writes, key rotation, readback, clr and reset
module tb_config_memory_unit;
    logic        clk = 0;
    logic        arst = 0;
    logic        write_en = 0;
    logic [34:0] configin = '0;
    logic        clr = 0;
    logic        rd_en = 0;
    logic [1:0]  rd_addr = '0;
    logic [1:0]  syskey;
    logic [34:0] rd_data;
    logic        rd_valid, rd_err, wr_ack, wr_err, full;
    logic [2:0]  count;
    logic [1:0]  dbg_state;
    int n_checks = 0;
    int n_fail = 0;

    config_memory_unit dut (
        .clk(clk), .arst(arst), .write_en(write_en), .configin(configin), .clr(clr),
        .rd_en(rd_en), .rd_addr(rd_addr), .syskey(syskey), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_err(rd_err), .wr_ack(wr_ack), .wr_err(wr_err),
        .full(full), .count(count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1; write_en = 0; clr = 0; rd_en = 0;
        step();
        arst = 0;
    endtask

    task automatic do_write(input logic [34:0] d, output logic ack, output logic err);
        write_en = 1; configin = d;
        step();
        step();
        ack = wr_ack; err = wr_err;
        write_en = 0;
        step();
    endtask

    task automatic do_read(input logic [1:0] a);
        rd_en = 1; rd_addr = a;
        step();
        rd_en = 0;
    endtask

    task automatic test_reset();
        arst = 1;
        step();
        step();
        arst = 0;
        n_checks++; if (syskey !== 2'b10) begin n_fail++; $display("FAIL reset_syskey got %b exp 10", syskey); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if ({wr_ack, wr_err, rd_valid, rd_err, full} !== 5'b0) begin n_fail++; $display("FAIL reset_pulses got %b exp 00000", {wr_ack, wr_err, rd_valid, rd_err, full}); end
        n_checks++; if (rd_data !== 35'h0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        n_checks++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b exp 00", dbg_state); end
    endtask

    task automatic test_write_readback();
        int acks = 0;
        write_en = 1; configin = 35'h1_2345_6789;
        step();
        n_checks++; if (dbg_state !== 2'b01) begin n_fail++; $display("FAIL wr_commit_state got %b exp 01", dbg_state); end
        configin = 35'h7_FFFF_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wr_ack) acks++;
        end
        n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL wr_ack_pulses got %0d exp 1", acks); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL wr_count got %0d exp 1", count); end
        n_checks++; if (syskey !== 2'b11) begin n_fail++; $display("FAIL wr_syskey got %b exp 11", syskey); end
        n_checks++; if (dbg_state !== 2'b10) begin n_fail++; $display("FAIL wr_hold_state got %b exp 10", dbg_state); end
        write_en = 0;
        step();
        n_checks++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL wr_idle_state got %b exp 00", dbg_state); end
        do_read(2'd0);
        n_checks++; if (rd_data !== 35'h1_2345_6789) begin n_fail++; $display("FAIL rd0_data got %h exp 123456789", rd_data); end
        n_checks++; if ({rd_valid, rd_err} !== 2'b10) begin n_fail++; $display("FAIL rd0_flags got %b exp 10", {rd_valid, rd_err}); end
        step();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse got %b exp 0", rd_valid); end
        n_checks++; if (rd_data !== 35'h1_2345_6789) begin n_fail++; $display("FAIL rd_data_hold got %h exp 123456789", rd_data); end
    endtask

    task automatic test_full();
        logic ack, err;
        logic [34:0] d [4] = '{35'h0_0000_0011, 35'h2_2222_2222, 35'h3_3333_3333, 35'h7_ABCD_EF01};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_write(d[i], ack, err);
            n_checks++; if ({ack, err} !== 2'b10) begin n_fail++; $display("FAIL full_wr%0d_resp got %b exp 10", i, {ack, err}); end
        end
        n_checks++; if ({full, count} !== 4'b1100) begin n_fail++; $display("FAIL full_count got full=%b count=%0d exp full=1 count=4", full, count); end
        n_checks++; if (syskey !== 2'b10) begin n_fail++; $display("FAIL full_key_wrap got %b exp 10", syskey); end
        do_write(35'h5_5555_5555, ack, err);
        n_checks++; if ({ack, err} !== 2'b01) begin n_fail++; $display("FAIL full_reject_resp got %b exp 01", {ack, err}); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_reject_count got %0d exp 4", count); end
        n_checks++; if (syskey !== 2'b10) begin n_fail++; $display("FAIL full_reject_key got %b exp 10", syskey); end
        do_read(2'd3);
        n_checks++; if (rd_data !== 35'h7_ABCD_EF01) begin n_fail++; $display("FAIL full_rd3 got %h exp 7abcdef01", rd_data); end
        do_read(2'd0);
        n_checks++; if (rd_data !== 35'h0_0000_0011) begin n_fail++; $display("FAIL full_rd0 got %h exp 11", rd_data); end
    endtask

    task automatic test_bad_read();
        logic ack, err;
        do_reset();
        do_write(35'h0_AAAA_5555, ack, err);
        do_read(2'd3);
        n_checks++; if ({rd_valid, rd_err} !== 2'b11) begin n_fail++; $display("FAIL bad_rd_flags got %b exp 11", {rd_valid, rd_err}); end
        n_checks++; if (rd_data !== 35'h0) begin n_fail++; $display("FAIL bad_rd_data got %h exp 0", rd_data); end
        write_en = 1; configin = 35'h4_0000_0001;
        step();
        rd_en = 1; rd_addr = 2'd1;
        step();
        rd_en = 0;
        n_checks++; if ({wr_ack, rd_err} !== 2'b11) begin n_fail++; $display("FAIL same_edge_rd got ack/err %b exp 11", {wr_ack, rd_err}); end
        write_en = 0;
        step();
        do_read(2'd1);
        n_checks++; if ({rd_err, rd_data} !== {1'b0, 35'h4_0000_0001}) begin n_fail++; $display("FAIL rd1_after got err=%b data=%h exp err=0 data=400000001", rd_err, rd_data); end
    endtask

    task automatic test_clr_commit();
        logic ack, err;
        do_reset();
        do_write(35'h1_0000_0000, ack, err);
        write_en = 1; configin = 35'h2_0000_0000;
        step();
        clr = 1;
        step();
        clr = 0;
        n_checks++; if ({wr_ack, wr_err} !== 2'b00) begin n_fail++; $display("FAIL clr_resp got %b exp 00", {wr_ack, wr_err}); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL clr_count got %0d exp 0", count); end
        n_checks++; if (syskey !== 2'b11) begin n_fail++; $display("FAIL clr_key got %b exp 11", syskey); end
        step();
        step();
        n_checks++; if ({dbg_state, wr_ack} !== 3'b100) begin n_fail++; $display("FAIL clr_hold got state=%b ack=%b exp state=10 ack=0", dbg_state, wr_ack); end
        write_en = 0;
        step();
        n_checks++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL clr_idle got %b exp 00", dbg_state); end
    endtask

    task automatic test_reset_midop();
        logic ack, err;
        do_reset();
        do_write(35'h0_0000_0001, ack, err);
        write_en = 1; configin = 35'h0_0000_0002;
        step();
        arst = 1;
        step();
        arst = 0; write_en = 0;
        n_checks++; if ({wr_ack, count, syskey, dbg_state} !== {1'b0, 3'd0, 2'b10, 2'b00}) begin n_fail++; $display("FAIL midop_reset got ack=%b count=%0d key=%b state=%b exp 0/0/10/00", wr_ack, count, syskey, dbg_state); end
        step();
        n_checks++; if ({wr_ack, count, dbg_state} !== 6'b0) begin n_fail++; $display("FAIL midop_after got ack=%b count=%0d state=%b exp 0/0/00", wr_ack, count, dbg_state); end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_full();
        test_bad_read();
        test_clr_commit();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
